// File: rtl/axi_bram_pkg.sv
// -----------------------------------------------------------------------------
// axi_bram_pkg
//   Definitions shared by the AXI4-Lite BRAM reader and writer:
//     RESP_OKAY / RESP_SLVERR : AXI response codes
//     rd_state_t              : reader FSM state encoding (IDLE, WAIT, RESP)
//     CNT_W                   : width of the BRAM latency counter (latency 1..4)
//     clog2()                 : ceiling log2, used for byte-lane/address math
// -----------------------------------------------------------------------------
package axi_bram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } rd_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/axi_bram_reader.sv
// -----------------------------------------------------------------------------
// axi_bram_reader
//   AXI4-Lite read-only slave. Each accepted AR beat becomes one BRAM port-A
//   word read; the captured word is returned on the R channel. One transaction
//   is outstanding at a time.
//
//   Ports:
//     aclk, areset          : clock, synchronous active-high reset
//     s_axi_ar*             : read address channel (araddr, arvalid, arready)
//     s_axi_r*              : read data channel (rdata, rresp, rvalid, rready)
//     bram_porta_clk/rst    : forwarded aclk / areset
//     bram_porta_addr       : registered word address
//     bram_porta_rddata     : BRAM read data
//
//   Optional feature macro: AXI_BRAM_READER_ALIGN_CHECK_EN
//     When defined, a read whose byte-offset bits are non-zero completes with
//     the normal latency but returns rresp=SLVERR and rdata=0.
// -----------------------------------------------------------------------------
module axi_bram_reader
   import axi_bram_pkg::*;
#(
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int BRAM_LATENCY    = 1
) (
   input  logic                       aclk,
   input  logic                       areset,

   input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic                       s_axi_arvalid,
   output logic                       s_axi_arready,

   output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
   output logic [1:0]                 s_axi_rresp,
   output logic                       s_axi_rvalid,
   input  logic                       s_axi_rready,

   output logic                       bram_porta_clk,
   output logic                       bram_porta_rst,
   output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] bram_porta_rddata
);

   localparam int unsigned ADDR_LSB = clog2(AXI_DATA_WIDTH / 8);

   rd_state_t                  r_state;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_arready;
   logic                       r_rvalid;
   logic [AXI_DATA_WIDTH-1:0]  r_rdata;
   logic [1:0]                 r_rresp;
   logic [BRAM_ADDR_WIDTH-1:0] r_addr;

   logic                       w_ar_hs;
   logic [BRAM_ADDR_WIDTH-1:0] w_word_addr;
   logic                       w_err;
   logic                       w_unused_addr;

   assign bram_porta_clk  = aclk;
   assign bram_porta_rst  = areset;
   assign bram_porta_addr = r_addr;

   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;

   assign w_ar_hs     = s_axi_arvalid & r_arready;
   // Upper address bits are dropped: the address wraps modulo BRAM depth.
   assign w_word_addr = s_axi_araddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
   assign w_unused_addr = ^s_axi_araddr;

`ifdef AXI_BRAM_READER_ALIGN_CHECK_EN
   logic r_err;

   // Misalignment flag, captured at acceptance, released by the R handshake.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_err <= 1'b0;
      end else if (w_ar_hs) begin
         r_err <= |s_axi_araddr[ADDR_LSB-1:0];
      end else if (r_state == RESP && s_axi_rready) begin
         r_err <= 1'b0;
      end
   end

   assign w_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   // The counter loads BRAM_LATENCY (not LATENCY-1): the first WAIT cycle is
   // the one in which the registered address reaches the BRAM, so the sample
   // lands BRAM_LATENCY cycles after that, giving rvalid at T+2+BRAM_LATENCY.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_addr    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ar_hs) begin
                  r_arready <= 1'b0;
                  r_addr    <= w_word_addr;
                  r_cnt     <= CNT_W'(BRAM_LATENCY);
                  r_state   <= WAIT;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  r_rdata  <= w_err ? '0 : bram_porta_rddata;
                  r_rresp  <= w_err ? RESP_SLVERR : RESP_OKAY;
                  r_rvalid <= 1'b1;
                  r_state  <= RESP;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (s_axi_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_bram_reader.sv
// -----------------------------------------------------------------------------
// tb_axi_bram_reader
//   Directed bench for axi_bram_reader. Two instances share one BRAM image:
//   index 0 uses BRAM_LATENCY=1, index 1 uses BRAM_LATENCY=3. Each has its own
//   BRAM read pipeline model. Memory word i holds {16'hC0DE, i}, except word 5
//   which holds 32'hDEADBEEF.
// -----------------------------------------------------------------------------
module tb_axi_bram_reader;

   logic        clk;
   logic        areset;
   logic [31:0] mem [1024];

   logic [31:0] araddr  [2];
   logic        arvalid [2];
   logic        arready [2];
   logic [31:0] rdata   [2];
   logic [1:0]  rresp   [2];
   logic        rvalid  [2];
   logic        rready  [2];
   logic        bclk    [2];
   logic        brst    [2];
   logic [9:0]  baddr   [2];
   logic [31:0] brd     [2];

   int checks;
   int errors;
   int cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [31:0] pipe [LAT];

      always @(posedge clk) begin
         pipe[0] <= mem[baddr[g]];
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign brd[g] = pipe[LAT-1];

      axi_bram_reader #(
         .AXI_DATA_WIDTH (32),
         .AXI_ADDR_WIDTH (32),
         .BRAM_DATA_WIDTH(32),
         .BRAM_ADDR_WIDTH(10),
         .BRAM_LATENCY   (LAT)
      ) u_dut (
         .aclk             (clk),
         .areset           (areset),
         .s_axi_araddr     (araddr[g]),
         .s_axi_arvalid    (arvalid[g]),
         .s_axi_arready    (arready[g]),
         .s_axi_rdata      (rdata[g]),
         .s_axi_rresp      (rresp[g]),
         .s_axi_rvalid     (rvalid[g]),
         .s_axi_rready     (rready[g]),
         .bram_porta_clk   (bclk[g]),
         .bram_porta_rst   (brst[g]),
         .bram_porta_addr  (baddr[g]),
         .bram_porta_rddata(brd[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One read: checks arready before the handshake, latency to rvalid,
   // data and response; with rready high also checks the return to IDLE.
   task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] ed,
                          input logic [1:0] er, input int elat, input string tag);
      int n;
      chk({tag, "_arready_pre"}, 64'(arready[d]), 64'd1);
      araddr[d]  = a;
      arvalid[d] = 1'b1;
      tick();
      arvalid[d] = 1'b0;
      n = 1;
      while (rvalid[d] !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(elat));
      chk({tag, "_rdata"}, 64'(rdata[d]), 64'(ed));
      chk({tag, "_rresp"}, 64'(rresp[d]), 64'(er));
      if (rready[d] === 1'b1) begin
         tick();
         chk({tag, "_post_rvalid_arready"}, 64'({rvalid[d], arready[d]}), 64'b01);
      end
   endtask

   initial begin
      int hs_prev;
      int n;
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i)};
      mem[5] = 32'hDEADBEEF;
      for (int d = 0; d < 2; d++) begin
         araddr[d]  = '0;
         arvalid[d] = 1'b0;
         rready[d]  = 1'b1;
      end
      areset = 1'b1;

      // Reset state
      tick(); tick(); tick();
      chk("rst_arready0", 64'(arready[0]), 64'd0);
      chk("rst_arready1", 64'(arready[1]), 64'd0);
      chk("rst_rvalid0",  64'(rvalid[0]),  64'd0);
      chk("rst_rdata0",   64'(rdata[0]),   64'd0);
      chk("rst_rresp0",   64'(rresp[0]),   64'd0);
      chk("rst_baddr0",   64'(baddr[0]),   64'd0);
      chk("rst_bram_rst", 64'(brst[0]),    64'd1);
      chk("bram_clk",     64'(bclk[0]),    64'(clk));
      areset = 1'b0;
      tick();
      chk("rel_arready0", 64'(arready[0]), 64'd1);
      chk("rel_arready1", 64'(arready[1]), 64'd1);
      chk("rel_bram_rst", 64'(brst[1]),    64'd0);

      // L=1: word 5 at 0x14, rvalid 3 cycles after the AR handshake
      do_read(0, 32'h14, 32'hDEADBEEF, 2'b00, 3, "rd_w5");
      chk("baddr_holds", 64'(baddr[0]), 64'd5);

      // L=3: back-to-back reads of words 0..3 with arvalid held high
      araddr[1]  = 32'h0;
      arvalid[1] = 1'b1;
      hs_prev = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (arready[1] !== 1'b1 && n < 30) begin
            tick();
            n++;
         end
         chk("b2b_arready", 64'(arready[1]), 64'd1);
         if (i > 0) chk("b2b_spacing", 64'(cyc - hs_prev), 64'd6);
         hs_prev = cyc;
         tick();
         if (i == 3) arvalid[1] = 1'b0;
         araddr[1] = 32'((i + 1) * 4);
         n = 1;
         while (rvalid[1] !== 1'b1 && n < 30) begin
            tick();
            n++;
         end
         chk("b2b_latency", 64'(n), 64'd5);
         chk("b2b_rdata", 64'(rdata[1]), 64'({16'hC0DE, 16'(i)}));
      end
      tick();

      // Backpressure: rready low for 10 cycles after rvalid rises
      rready[0] = 1'b0;
      do_read(0, 32'h1C, 32'hC0DE0007, 2'b00, 3, "bp");
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", 64'({rvalid[0], rdata[0], rresp[0], arready[0]}),
             64'({1'b1, 32'hC0DE0007, 2'b00, 1'b0}));
      end
      rready[0] = 1'b1;
      tick();
      chk("bp_release", 64'({rvalid[0], arready[0]}), 64'b01);

      // Address wrap: 0x1008 with 10-bit word address -> word 2
      do_read(0, 32'h1008, 32'hC0DE0002, 2'b00, 3, "wrap");

      // Reset while in WAIT (L=3)
      chk("rw_arready_pre", 64'(arready[1]), 64'd1);
      araddr[1]  = 32'h24;
      arvalid[1] = 1'b1;
      tick();
      arvalid[1] = 1'b0;
      tick();
      areset = 1'b1;
      tick();
      chk("rw_in_reset", 64'({rvalid[1], arready[1]}), 64'b00);
      areset = 1'b0;
      tick();
      chk("rw_rel_arready", 64'(arready[1]), 64'd1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rvalid[1] !== 1'b0) n++;
      end
      chk("rw_no_stale", 64'(n), 64'd0);
      chk("rw_arready_idle", 64'(arready[1]), 64'd1);

      // Misaligned read, then an aligned one
`ifdef AXI_BRAM_READER_ALIGN_CHECK_EN
      do_read(0, 32'h06, 32'h0, 2'b10, 3, "misal");
`else
      do_read(0, 32'h06, 32'hC0DE0001, 2'b00, 3, "misal");
`endif
      do_read(0, 32'h08, 32'hC0DE0002, 2'b00, 3, "align");
      do_read(1, 32'h08, 32'hC0DE0002, 2'b00, 5, "align_l3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
